// File: rtl/power_mode_sequencer_pkg.sv
// pm_pkg: power-mode constants shared with the clock gating controller, plus state encodings.
package pm_pkg;
    localparam logic [1:0] MODE_DEEPSLEEP = 2'b00;
    localparam logic [1:0] MODE_STANDBY   = 2'b01;
    localparam logic [1:0] MODE_ACTIVE    = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL   = 2'b11;

    typedef enum logic [2:0] {
        ST_ACTIVE    = 3'd0,
        ST_DRAIN     = 3'd1,
        ST_STANDBY   = 3'd2,
        ST_DEEPSLEEP = 3'd3,
        ST_WAKE      = 3'd4
    } pm_state_e;

    function automatic logic [1:0] state_mode(pm_state_e s);
        return (s == ST_STANDBY || s == ST_WAKE) ? MODE_STANDBY :
               (s == ST_DEEPSLEEP) ? MODE_DEEPSLEEP : MODE_ACTIVE;
    endfunction
endpackage

// File: rtl/power_mode_sequencer_if.sv
// power_mode_sequencer_if: software mode-request valid/ready handshake.
interface power_mode_sequencer_if;
    logic       mode_req_valid;
    logic [1:0] mode_req;
    logic       mode_req_ready;
    modport master(output mode_req_valid, mode_req, input mode_req_ready);
    modport slave(input mode_req_valid, mode_req, output mode_req_ready);
endinterface

// File: rtl/power_mode_sequencer_activity_monitor.sv
// pm_activity_monitor: idle counter for auto-demotion and two-sample quiet detector for DRAIN exit.
module pm_activity_monitor #(
    parameter int IDLE_CNT_W = 16
) (
    input  logic                  clk_master,
    input  logic                  rst_n,
    input  logic                  in_active_i,
    input  logic                  in_drain_i,
    input  logic                  busy_i,
    input  logic                  req_valid_i,
    input  logic [IDLE_CNT_W-1:0] idle_timeout_i,
    output logic                  idle_expired_o,
    output logic                  quiet2_o
);
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [IDLE_CNT_W:0]   idle_next;
    logic                  quiet1_q;
    logic                  idle_tick;

    always_comb begin
        idle_tick      = in_active_i && !busy_i && !req_valid_i;
        idle_next      = {1'b0, idle_cnt_q} + 1'b1;
        idle_cnt_d     = !idle_tick ? '0 : (&idle_cnt_q) ? idle_cnt_q : idle_next[IDLE_CNT_W-1:0];
        // expiry is judged on the count this quiet sample produces, so DRAIN follows the N-th sample
        idle_expired_o = idle_tick && idle_timeout_i != '0 && idle_next >= {1'b0, idle_timeout_i};
        quiet2_o       = in_drain_i && quiet1_q && !busy_i;
    end

    always_ff @(posedge clk_master) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
            quiet1_q   <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            quiet1_q   <= in_drain_i && !busy_i;
        end
    end
endmodule

// File: rtl/power_mode_sequencer.sv
// power_mode_sequencer: chip power-mode FSM (Active/Standby/DeepSleep) with drain, auto-demote and wake settle.
module power_mode_sequencer
    import pm_pkg::*;
#(
    parameter int IDLE_CNT_W    = 16,
    parameter int WAKE_SETTLE   = 8,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                  clk_master,
    input  logic                  rst_n,
    power_mode_sequencer_if.slave req,
    input  logic [IDLE_CNT_W-1:0] idle_timeout,
    input  logic                  cim_active,
    input  logic                  dvfs_busy,
    input  logic                  uart_active,
    input  logic                  wakeup_request,
    input  logic [3:0]            wakeup_source,
    output logic [1:0]            power_mode,
    output logic                  hold_new_work,
    output logic                  mode_done,
    output logic                  req_error,
    output logic [3:0]            wake_cause,
    output logic [2:0]            state_dbg
);
    localparam int DW = $clog2(DRAIN_TIMEOUT);
    localparam int SW = $clog2(WAKE_SETTLE + 1);

    pm_state_e      state_q, state_d, target_q, target_d;
    logic [DW-1:0]  drain_cnt_q, drain_cnt_d;
    logic [SW-1:0]  settle_cnt_q, settle_cnt_d;
    logic           ready_q, done_d, err_d;
    logic [3:0]     cause_d;
    logic           busy, wake, accept, idle_expired, quiet2;

    assign busy               = cim_active | dvfs_busy | uart_active;
    // a wake in a low-power state pre-empts any same-cycle software request
    assign wake               = wakeup_request && (state_q == ST_STANDBY || state_q == ST_DEEPSLEEP);
    assign req.mode_req_ready = ready_q && !wake;
    assign accept             = req.mode_req_valid && req.mode_req_ready;

    pm_activity_monitor #(.IDLE_CNT_W(IDLE_CNT_W)) u_mon (
        .clk_master     (clk_master),
        .rst_n          (rst_n),
        .in_active_i    (state_q == ST_ACTIVE),
        .in_drain_i     (state_q == ST_DRAIN),
        .busy_i         (busy),
        .req_valid_i    (req.mode_req_valid),
        .idle_timeout_i (idle_timeout),
        .idle_expired_o (idle_expired),
        .quiet2_o       (quiet2)
    );

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        cause_d      = wake_cause;
        done_d       = 1'b0;
        err_d        = 1'b0;
        drain_cnt_d  = '0;
        settle_cnt_d = '0;
        if (accept && req.mode_req == MODE_ILLEGAL) begin
            err_d = 1'b1;
        end else begin
            case (state_q)
                ST_ACTIVE: begin
                    if (accept && req.mode_req == MODE_ACTIVE) begin
                        done_d = 1'b1;
                    end else if (accept) begin
                        state_d  = ST_DRAIN;
                        target_d = (req.mode_req == MODE_STANDBY) ? ST_STANDBY : ST_DEEPSLEEP;
                    end else if (idle_expired) begin
                        state_d  = ST_DRAIN;
                        target_d = ST_STANDBY;
                    end
                end
                ST_DRAIN: begin
                    if (wakeup_request) begin
                        state_d = ST_ACTIVE;
                        cause_d = wakeup_source;
                    end else if (quiet2) begin
                        state_d = target_q;
                        done_d  = 1'b1;
                    end else if (drain_cnt_q == DW'(DRAIN_TIMEOUT - 1)) begin
                        state_d = ST_ACTIVE;
                        err_d   = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end
                ST_STANDBY, ST_DEEPSLEEP: begin
                    if (wake) begin
                        state_d = ST_WAKE;
                        cause_d = wakeup_source;
                    end else if (accept) begin
                        if (req.mode_req == state_mode(state_q)) begin
                            done_d = 1'b1;
                        end else if (req.mode_req == MODE_DEEPSLEEP) begin
                            state_d  = ST_DRAIN;
                            target_d = ST_DEEPSLEEP;
                        end else begin
                            state_d = ST_WAKE;
                            cause_d = '0;
                        end
                    end
                end
                ST_WAKE: begin
                    if (settle_cnt_q == SW'(WAKE_SETTLE - 1)) begin
                        state_d = ST_ACTIVE;
                        done_d  = 1'b1;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk_master) begin
        if (!rst_n) begin
            state_q       <= ST_ACTIVE;
            target_q      <= ST_STANDBY;
            drain_cnt_q   <= '0;
            settle_cnt_q  <= '0;
            ready_q       <= 1'b1;
            power_mode    <= MODE_ACTIVE;
            hold_new_work <= 1'b0;
            mode_done     <= 1'b0;
            req_error     <= 1'b0;
            wake_cause    <= '0;
            state_dbg     <= '0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            drain_cnt_q   <= drain_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            ready_q       <= state_d inside {ST_ACTIVE, ST_STANDBY, ST_DEEPSLEEP};
            power_mode    <= state_mode(state_d);
            hold_new_work <= state_d inside {ST_DRAIN, ST_DEEPSLEEP, ST_WAKE};
            mode_done     <= done_d;
            req_error     <= err_d;
            wake_cause    <= cause_d;
            state_dbg     <= state_d;
        end
    end
endmodule

// File: tb/tb_power_mode_sequencer.sv
// tb_power_mode_sequencer: directed scenarios plus random traffic checked against a rule-level model.
module tb_power_mode_sequencer;
    localparam int IDLE_CNT_W    = 16;
    localparam int WAKE_SETTLE   = 8;
    localparam int DRAIN_TIMEOUT = 1024;
    localparam int IDLE_MAX      = (1 << IDLE_CNT_W) - 1;
    localparam logic [12:0] RESET_VEC = {2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0};

    logic                  clk_master = 1'b0;
    logic                  rst_n;
    logic [IDLE_CNT_W-1:0] idle_timeout;
    logic                  cim_active, dvfs_busy, uart_active, wakeup_request;
    logic [3:0]            wakeup_source;
    logic [1:0]            power_mode;
    logic                  hold_new_work, mode_done, req_error;
    logic [3:0]            wake_cause;
    logic [2:0]            state_dbg;
    int                    n_cmp = 0;
    int                    n_fail = 0;

    power_mode_sequencer_if ifc();

    power_mode_sequencer #(
        .IDLE_CNT_W(IDLE_CNT_W), .WAKE_SETTLE(WAKE_SETTLE), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) dut (
        .clk_master(clk_master), .rst_n(rst_n), .req(ifc), .idle_timeout(idle_timeout),
        .cim_active(cim_active), .dvfs_busy(dvfs_busy), .uart_active(uart_active),
        .wakeup_request(wakeup_request), .wakeup_source(wakeup_source),
        .power_mode(power_mode), .hold_new_work(hold_new_work), .mode_done(mode_done),
        .req_error(req_error), .wake_cause(wake_cause), .state_dbg(state_dbg)
    );

    always #5 clk_master = ~clk_master;

    // model: 0 Active, 1 Drain, 2 Standby, 3 DeepSleep, 4 Wake; counts are cycles spent / samples seen
    int         m_st = 0, m_tgt = 2, m_dcyc = 0, m_qrun = 0, m_idle = 0, m_settle = 0;
    logic       m_done = 1'b0, m_err = 1'b0;
    logic [3:0] m_cause = 4'h0;
    int         pm_tab[5] = '{2, 2, 1, 0, 1};

    function automatic logic m_ready();
        return !(m_st == 1 || m_st == 4) && !(wakeup_request && (m_st == 2 || m_st == 3));
    endfunction

    function automatic logic [12:0] expv();
        return {2'(pm_tab[m_st]), (m_st == 1 || m_st == 3 || m_st == 4), m_ready(), m_done, m_err, m_cause, 3'(m_st)};
    endfunction

    function automatic logic [12:0] obs();
        return {power_mode, hold_new_work, ifc.mode_req_ready, mode_done, req_error, wake_cause, state_dbg};
    endfunction

    task automatic model_edge();
        logic busy, acc;
        int   r, nxt;
        busy   = cim_active | dvfs_busy | uart_active;
        acc    = ifc.mode_req_valid && m_ready();
        r      = int'(ifc.mode_req);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!rst_n) begin
            m_st = 0; m_dcyc = 0; m_qrun = 0; m_idle = 0; m_settle = 0; m_cause = 4'h0;
            return;
        end
        nxt = m_st;
        m_idle = (m_st == 0 && !busy && !ifc.mode_req_valid) ? (m_idle < IDLE_MAX ? m_idle + 1 : m_idle) : 0;
        if (acc && r == 3) m_err = 1'b1;
        else if (m_st == 0) begin
            if (acc && r == 2) m_done = 1'b1;
            else if (acc) begin nxt = 1; m_tgt = (r == 1) ? 2 : 3; end
            else if (idle_timeout != 0 && m_idle >= int'(idle_timeout)) begin nxt = 1; m_tgt = 2; end
        end else if (m_st == 1) begin
            m_dcyc++;
            m_qrun = busy ? 0 : m_qrun + 1;
            if (wakeup_request) begin nxt = 0; m_cause = wakeup_source; end
            else if (m_qrun >= 2) begin nxt = m_tgt; m_done = 1'b1; end
            else if (m_dcyc >= DRAIN_TIMEOUT) begin nxt = 0; m_err = 1'b1; end
        end else if (m_st == 2 || m_st == 3) begin
            if (wakeup_request) begin nxt = 4; m_cause = wakeup_source; end
            else if (acc) begin
                if ((m_st == 2 && r == 1) || (m_st == 3 && r == 0)) m_done = 1'b1;
                else if (m_st == 2 && r == 0) begin nxt = 1; m_tgt = 3; end
                else begin nxt = 4; m_cause = 4'h0; end
            end
        end else begin
            m_settle++;
            if (m_settle >= WAKE_SETTLE) begin nxt = 0; m_done = 1'b1; end
        end
        if (nxt != m_st) begin m_dcyc = 0; m_qrun = 0; m_settle = 0; end
        m_st = nxt;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk_master);
        #1;
    endtask

    task automatic request(input logic [1:0] mode);
        ifc.mode_req_valid = 1'b1;
        ifc.mode_req       = mode;
        tick();
        ifc.mode_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (obs() !== RESET_VEC) begin n_fail++; $display("FAIL reset: got %b want %b", obs(), RESET_VEC); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_hold();
        idle_timeout = '0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n_cmp++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL idle_hold cyc %0d: got %b want %b", i, obs(), expv()); end
        end
        n_cmp++;
        if ({power_mode, state_dbg, ifc.mode_req_ready} !== {2'b10, 3'd0, 1'b1}) begin
            n_fail++; $display("FAIL idle_hold_end: got %b want %b", {power_mode, state_dbg, ifc.mode_req_ready}, 6'b10_000_1);
        end
    endtask

    task automatic test_drain_standby();
        cim_active = 1'b1;
        request(2'b01);
        n_cmp++;
        if ({state_dbg, hold_new_work, power_mode} !== {3'd1, 1'b1, 2'b10}) begin
            n_fail++; $display("FAIL drain_enter: got %b want %b", {state_dbg, hold_new_work, power_mode}, 6'b001_1_10);
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 4) cim_active = 1'b0;
            tick();
            n_cmp++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL drain_standby cyc %0d: got %b want %b", i, obs(), expv()); end
        end
        n_cmp++;
        if ({power_mode, mode_done, state_dbg} !== {2'b01, 1'b1, 3'd2}) begin
            n_fail++; $display("FAIL standby_reached: got %b want %b", {power_mode, mode_done, state_dbg}, 6'b01_1_010);
        end
    endtask

    task automatic test_deepsleep_wake();
        request(2'b00);
        tick();
        tick();
        n_cmp++;
        if ({power_mode, mode_done, state_dbg} !== {2'b00, 1'b1, 3'd3}) begin
            n_fail++; $display("FAIL deepsleep_reached: got %b want %b", {power_mode, mode_done, state_dbg}, 6'b00_1_011);
        end
        wakeup_request = 1'b1;
        wakeup_source  = 4'b0010;
        tick();
        wakeup_request = 1'b0;
        wakeup_source  = 4'b0000;
        for (int i = 0; i < WAKE_SETTLE - 1; i++) begin
            n_cmp++;
            if ({state_dbg, power_mode, hold_new_work} !== {3'd4, 2'b01, 1'b1}) begin
                n_fail++; $display("FAIL wake_settle cyc %0d: got %b want %b", i, {state_dbg, power_mode, hold_new_work}, 6'b100_01_1);
            end
            tick();
        end
        n_cmp++;
        if (obs() !== expv()) begin n_fail++; $display("FAIL wake_last: got %b want %b", obs(), expv()); end
        tick();
        n_cmp++;
        if ({state_dbg, mode_done, wake_cause, power_mode} !== {3'd0, 1'b1, 4'b0010, 2'b10}) begin
            n_fail++; $display("FAIL wake_active: got %b want %b", {state_dbg, mode_done, wake_cause, power_mode}, 10'b000_1_0010_10);
        end
    endtask

    task automatic test_auto_demote();
        idle_timeout = 16'd4;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_cmp++;
            if (state_dbg !== (i < 4 ? 3'd0 : i < 6 ? 3'd1 : 3'd2)) begin
                n_fail++; $display("FAIL auto_demote cyc %0d: got state %0d want %0d", i, state_dbg, i < 4 ? 0 : i < 6 ? 1 : 2);
            end
            n_cmp++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL auto_demote_model cyc %0d: got %b want %b", i, obs(), expv()); end
        end
        idle_timeout = '0;
        request(2'b10);
        for (int i = 0; i < WAKE_SETTLE; i++) tick();
        n_cmp++;
        if ({state_dbg, mode_done, wake_cause} !== {3'd0, 1'b1, 4'h0}) begin
            n_fail++; $display("FAIL sw_wake: got %b want %b", {state_dbg, mode_done, wake_cause}, 8'b000_1_0000);
        end
    endtask

    task automatic test_illegal();
        request(2'b11);
        n_cmp++;
        if ({req_error, mode_done, state_dbg, ifc.mode_req_ready} !== {1'b1, 1'b0, 3'd0, 1'b1}) begin
            n_fail++; $display("FAIL illegal: got %b want %b", {req_error, mode_done, state_dbg, ifc.mode_req_ready}, 6'b1_0_000_1);
        end
        tick();
        n_cmp++;
        if (obs() !== expv()) begin n_fail++; $display("FAIL illegal_after: got %b want %b", obs(), expv()); end
    endtask

    task automatic test_drain_timeout();
        dvfs_busy = 1'b1;
        request(2'b00);
        for (int i = 1; i <= DRAIN_TIMEOUT; i++) begin
            tick();
            n_cmp++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL drain_timeout cyc %0d: got %b want %b", i, obs(), expv()); end
            if (i == DRAIN_TIMEOUT - 1) begin
                n_cmp++;
                if ({state_dbg, req_error} !== {3'd1, 1'b0}) begin
                    n_fail++; $display("FAIL timeout_early: got %b want %b", {state_dbg, req_error}, 4'b001_0);
                end
            end
        end
        n_cmp++;
        if ({state_dbg, req_error, mode_done, power_mode} !== {3'd0, 1'b1, 1'b0, 2'b10}) begin
            n_fail++; $display("FAIL timeout_abort: got %b want %b", {state_dbg, req_error, mode_done, power_mode}, 7'b000_1_0_10);
        end
        dvfs_busy = 1'b0;
    endtask

    task automatic test_wake_vs_req();
        request(2'b00);
        tick();
        tick();
        ifc.mode_req_valid = 1'b1;
        ifc.mode_req       = 2'b10;
        wakeup_request     = 1'b1;
        wakeup_source      = 4'b0100;
        #1;
        n_cmp++;
        if (ifc.mode_req_ready !== 1'b0) begin n_fail++; $display("FAIL wake_blocks_ready: got %b want 0", ifc.mode_req_ready); end
        tick();
        ifc.mode_req_valid = 1'b0;
        wakeup_request     = 1'b0;
        n_cmp++;
        if ({state_dbg, wake_cause} !== {3'd4, 4'b0100}) begin
            n_fail++; $display("FAIL wake_wins: got %b want %b", {state_dbg, wake_cause}, 7'b100_0100);
        end
        for (int i = 0; i < WAKE_SETTLE; i++) begin
            tick();
            n_cmp++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL wake_vs_req cyc %0d: got %b want %b", i, obs(), expv()); end
        end
    endtask

    task automatic test_reset_in_drain();
        cim_active = 1'b1;
        request(2'b01);
        tick();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (obs() !== RESET_VEC) begin n_fail++; $display("FAIL reset_in_drain: got %b want %b", obs(), RESET_VEC); end
        rst_n      = 1'b1;
        cim_active = 1'b0;
        tick();
        n_cmp++;
        if (obs() !== expv()) begin n_fail++; $display("FAIL after_reset: got %b want %b", obs(), expv()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) idle_timeout = IDLE_CNT_W'($urandom_range(0, 6));
            rst_n              = ($urandom_range(0, 299) != 0);
            ifc.mode_req_valid = ($urandom_range(0, 5) == 0);
            ifc.mode_req       = 2'($urandom_range(0, 3));
            cim_active         = ($urandom_range(0, 5) == 0);
            dvfs_busy          = ($urandom_range(0, 9) == 0);
            uart_active        = ($urandom_range(0, 9) == 0);
            wakeup_request     = ($urandom_range(0, 19) == 0);
            wakeup_source      = 4'($urandom_range(0, 15));
            tick();
            n_cmp++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL random cyc %0d: got %b want %b", i, obs(), expv()); end
        end
    endtask

    initial begin
        rst_n              = 1'b0;
        idle_timeout       = '0;
        cim_active         = 1'b0;
        dvfs_busy          = 1'b0;
        uart_active        = 1'b0;
        wakeup_request     = 1'b0;
        wakeup_source      = 4'h0;
        ifc.mode_req_valid = 1'b0;
        ifc.mode_req       = 2'b10;
        test_reset();
        test_idle_hold();
        test_drain_standby();
        test_deepsleep_wake();
        test_auto_demote();
        test_illegal();
        test_drain_timeout();
        test_wake_vs_req();
        test_reset_in_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
